bi_mem_wm_requester: RTL and testbench

Initiator for the write-masked single-port memory interface. Converts a valid/ready request stream (read or masked write) into memory-side enable/isWrite/mask/addr/data strobes and honours the memory's hold. Captures read data at its fixed one-cycle latency into a response FIFO, so upstream masters (DMA, core LSU) never see memory timing directly.

---
 rtl/bi_mem_wm_pkg.sv | 19 +
 rtl/bi_mem_wm_requester_if.sv | 45 ++++
 rtl/bi_mem_wm_rsp_fifo.sv | 42 ++++
 rtl/bi_mem_wm_requester.sv | 85 ++++++++
 tb/tb_bi_mem_wm_requester.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bi_mem_wm_pkg.sv
// bi_mem_wm_pkg: shared address-width helper and default request layout for the write-masked memory requester
package bi_mem_wm_pkg;
   localparam int DEF_WIDTH  = 16;
   localparam int DEF_HEIGHT = 16;
   localparam int DEF_MASK   = 4;

   function automatic int addr_w(int height);
      return height > 1 ? $clog2(height) : 1;
   endfunction

   localparam int DEF_AW = addr_w(DEF_HEIGHT);

   typedef struct packed {
      logic                  is_write;
      logic [DEF_MASK-1:0]   mask;
      logic [DEF_AW-1:0]     addr;
      logic [DEF_WIDTH-1:0]  data;
   } req_t;
endpackage

// File: rtl/bi_mem_wm_requester_if.sv
// bi_mem_wm_requester_if: request, response and memory-side signals of the requester (rspIsWrite_o only with BI_MEM_WM_REQUESTER_WRACK_EN)
interface bi_mem_wm_requester_if #(
   parameter int WIDTH  = 16,
   parameter int HEIGHT = 16,
   parameter int MASK   = 4
);
   import bi_mem_wm_pkg::*;
   localparam int AW = addr_w(HEIGHT);

   logic             reqValid_i;
   logic             reqReady_o;
   logic             reqIsWrite_i;
   logic [MASK-1:0]  reqMask_i;
   logic [AW-1:0]    reqAddr_i;
   logic [WIDTH-1:0] reqData_i;
   logic             rspValid_o;
   logic             rspReady_i;
   logic [WIDTH-1:0] rspData_o;
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
   logic             rspIsWrite_o;
`endif
   logic             memEnable_o;
   logic             memIsWrite_o;
   logic [MASK-1:0]  memWriteMask_o;
   logic [AW-1:0]    memAddr_o;
   logic [WIDTH-1:0] memWriteData_o;
   logic [WIDTH-1:0] memReadData_i;
   logic             memHold_i;

   modport master (
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
      output rspIsWrite_o,
`endif
      input  reqValid_i, reqIsWrite_i, reqMask_i, reqAddr_i, reqData_i, rspReady_i, memReadData_i, memHold_i,
      output reqReady_o, rspValid_o, rspData_o, memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o, memWriteData_o
   );

   modport slave (
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
      input  rspIsWrite_o,
`endif
      output reqValid_i, reqIsWrite_i, reqMask_i, reqAddr_i, reqData_i, rspReady_i, memReadData_i, memHold_i,
      input  reqReady_o, rspValid_o, rspData_o, memEnable_o, memIsWrite_o, memWriteMask_o, memAddr_o, memWriteData_o
   );
endinterface

// File: rtl/bi_mem_wm_rsp_fifo.sv
// bi_mem_wm_rsp_fifo: synchronous response FIFO, any depth >= 2, pointers wrap modulo DEPTH
module bi_mem_wm_rsp_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           pushData,
   input  logic                       pop,
   output logic [WIDTH-1:0]           popData,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr;
   logic [PW-1:0]    rd;

   function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
      return p == PW'(DEPTH-1) ? '0 : p + PW'(1);
   endfunction

   // pointers and occupancy; push and pop together leave the count unchanged
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= inc(wr);
         if (pop) rd <= inc(rd);
         count <= count + CW'(push) - CW'(pop);
      end

   // storage needs no reset: only entries below count are ever presented
   always_ff @(posedge clk)
      if (push) mem[wr] <= pushData;

   assign popData = mem[rd];
endmodule

// File: rtl/bi_mem_wm_requester.sv
// bi_mem_wm_requester: valid/ready to write-masked memory initiator with credit-gated read response FIFO; BI_MEM_WM_REQUESTER_WRACK_EN adds write acknowledges
module bi_mem_wm_requester
   import bi_mem_wm_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int HEIGHT    = DEF_HEIGHT,
   parameter int MASK      = DEF_MASK,
   parameter int RSP_DEPTH = 3
) (
   input logic clk_i,
   input logic reset_n_i,
   bi_mem_wm_requester_if.master bus
);
   localparam int CW = $clog2(RSP_DEPTH+1);
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
   localparam int FW = WIDTH + 1;
`else
   localparam int FW = WIDTH;
`endif

   logic          pending;
   logic [CW-1:0] count;
   logic          credit;
   logic          need;
   logic          accept;
   logic          pop;
   logic [FW-1:0] push_data;
   logic [FW-1:0] head;

   // credit looks only at registered state so rspReady_i never reaches reqReady_o
   assign credit = (int'(count) + int'(pending)) < RSP_DEPTH;
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
   assign need = credit;
`else
   assign need = bus.reqIsWrite_i || credit;
`endif

   assign bus.memEnable_o    = bus.reqValid_i && need;
   assign bus.reqReady_o     = need && !bus.memHold_i;
   assign accept             = bus.memEnable_o && !bus.memHold_i;
   assign bus.memIsWrite_o   = bus.reqIsWrite_i;
   assign bus.memWriteMask_o = bus.reqIsWrite_i ? bus.reqMask_i : '0;
   assign bus.memAddr_o      = bus.reqAddr_i;
   assign bus.memWriteData_o = bus.reqData_i;
   assign bus.rspValid_o     = count != '0;
   assign pop                = bus.rspValid_o && bus.rspReady_i;

`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
   logic pending_wr;

   // every accepted access owes one response entry in the following cycle
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         pending    <= 1'b0;
         pending_wr <= 1'b0;
      end else begin
         pending    <= accept;
         pending_wr <= accept && bus.reqIsWrite_i;
      end

   assign push_data = pending_wr ? {1'b1, {WIDTH{1'b0}}} : {1'b0, bus.memReadData_i};
   assign {bus.rspIsWrite_o, bus.rspData_o} = head;
`else
   // a read accepted now has its data on memReadData_i next cycle, hold or not
   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) pending <= 1'b0;
      else pending <= accept && !bus.reqIsWrite_i;

   assign push_data  = bus.memReadData_i;
   assign bus.rspData_o = head;
`endif

   bi_mem_wm_rsp_fifo #(.WIDTH(FW), .DEPTH(RSP_DEPTH)) u_fifo (
      .clk      (clk_i),
      .rst_n    (reset_n_i),
      .push     (pending),
      .pushData (push_data),
      .pop      (pop),
      .popData  (head),
      .count    (count)
   );

   a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      int'(count) + int'(pending) <= RSP_DEPTH);
endmodule

// File: tb/tb_bi_mem_wm_requester.sv
// tb_bi_mem_wm_requester: randomized bench with a request-level memory/response model
module tb_bi_mem_wm_requester;
   import bi_mem_wm_pkg::*;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int M  = 4;
   localparam int D  = 3;
   localparam int AW = 4;
   localparam int LW = W / M;
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
   localparam bit WRACK = 1'b1;
`else
   localparam bit WRACK = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] data;
      logic         isw;
      int           due;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   bi_mem_wm_requester_if #(.WIDTH(W), .HEIGHT(H), .MASK(M)) bus ();
   bi_mem_wm_requester #(.WIDTH(W), .HEIGHT(H), .MASK(M), .RSP_DEPTH(D)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus.master)
   );

   function automatic logic [W-1:0] init_val(int i);
      return W'(i * 16'h0123 + 16'h5A5A);
   endfunction

   // memory environment: masked writes on accept, read data one cycle later, garbage otherwise
   logic [W-1:0] mem [H];
   bit env_init = 1'b0;
   always @(posedge clk) begin
      if (!env_init) begin
         for (int i = 0; i < H; i++) mem[i] <= init_val(i);
         env_init <= 1'b1;
      end else if (bus.memEnable_o && !bus.memHold_i && bus.memIsWrite_o)
         for (int l = 0; l < M; l++)
            if (bus.memWriteMask_o[l]) mem[bus.memAddr_o][l*LW +: LW] <= bus.memWriteData_o[l*LW +: LW];
      bus.memReadData_i <= (bus.memEnable_o && !bus.memHold_i && !bus.memIsWrite_o) ? mem[bus.memAddr_o] : W'($urandom);
   end

   int vectors = 0;
   int errors = 0;
   int cyc = 0;
   logic [W-1:0] ref_mem [H];
   ent_t q[$];
   int outstanding = 0;
   bit acc = 1'b0;
   req_t pend[$];
   req_t cur;
   bit have_cur = 1'b0;
   int n_acc = 0;
   int n_stall = 0;
   int n_pop = 0;
   int acc_cyc = 0;
   int rv_rise = 0;
   bit prev_rv = 1'b0;
   int pop_cyc[$];
   logic [W-1:0] last_rsp = '0;
   logic [2:0] wr_seq = '0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // request-level model: credit = responses owed and not yet consumed; a response shows 2 cycles after accept
   task automatic compare();
      bit need, ex_en, ex_rdy, ex_rv;
      acc = 1'b0;
      if (!reset_n) begin
         q.delete();
         outstanding = 0;
         prev_rv = 1'b0;
         return;
      end
      need   = (bus.reqIsWrite_i && !WRACK) || outstanding < D;
      ex_en  = bus.reqValid_i && need;
      ex_rdy = need && !bus.memHold_i;
      ex_rv  = q.size() > 0 && q[0].due <= cyc;
      chk("reqReady", 32'(bus.reqReady_o), 32'(ex_rdy));
      chk("memEnable", 32'(bus.memEnable_o), 32'(ex_en));
      if (ex_en) begin
         chk("memIsWrite", 32'(bus.memIsWrite_o), 32'(bus.reqIsWrite_i));
         chk("memAddr", 32'(bus.memAddr_o), 32'(bus.reqAddr_i));
         chk("memWriteData", 32'(bus.memWriteData_o), 32'(bus.reqData_i));
         chk("memWriteMask", 32'(bus.memWriteMask_o), bus.reqIsWrite_i ? 32'(bus.reqMask_i) : 32'd0);
      end
      chk("rspValid", 32'(bus.rspValid_o), 32'(ex_rv));
      if (ex_rv) begin
         chk("rspData", 32'(bus.rspData_o), 32'(q[0].data));
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
         chk("rspIsWrite", 32'(bus.rspIsWrite_o), 32'(q[0].isw));
`endif
      end
      if (bus.reqValid_i && bus.reqReady_o) begin n_acc++; acc_cyc = cyc; end
      if (bus.reqValid_i && !bus.reqReady_o) n_stall++;
      if (bus.rspValid_o && !prev_rv) rv_rise = cyc;
      prev_rv = bus.rspValid_o;
      if (bus.rspValid_o && bus.rspReady_i) begin
         n_pop++;
         pop_cyc.push_back(cyc);
         last_rsp = bus.rspData_o;
`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
         wr_seq = {wr_seq[1:0], bus.rspIsWrite_o};
`endif
      end
      if (ex_rv && bus.rspReady_i) begin
         void'(q.pop_front());
         outstanding--;
      end
      if (bus.reqValid_i && ex_rdy) begin
         acc = 1'b1;
         if (bus.reqIsWrite_i) begin
            for (int l = 0; l < M; l++)
               if (bus.reqMask_i[l]) ref_mem[bus.reqAddr_i][l*LW +: LW] = bus.reqData_i[l*LW +: LW];
            if (WRACK) begin
               q.push_back('{data: '0, isw: 1'b1, due: cyc + 2});
               outstanding++;
            end
         end else begin
            q.push_back('{data: ref_mem[bus.reqAddr_i], isw: 1'b0, due: cyc + 2});
            outstanding++;
         end
      end
   endtask

   // one cycle: drive just after the rising edge, check on the falling edge
   task automatic tick(int vp, int hp, int rp);
      @(posedge clk);
      cyc++;
      #1;
      if (have_cur && acc) have_cur = 1'b0;
      if (!have_cur && pend.size() > 0 && $urandom_range(99) < vp) begin
         cur = pend.pop_front();
         have_cur = 1'b1;
      end
      bus.reqValid_i   = have_cur;
      bus.reqIsWrite_i = have_cur ? cur.is_write : 1'($urandom);
      bus.reqMask_i    = have_cur ? cur.mask : M'($urandom);
      bus.reqAddr_i    = have_cur ? cur.addr : AW'($urandom);
      bus.reqData_i    = have_cur ? cur.data : W'($urandom);
      bus.memHold_i    = $urandom_range(99) < hp;
      bus.rspReady_i   = $urandom_range(99) < rp;
      @(negedge clk);
      compare();
   endtask

   task automatic issue_all(int vp, int hp, int rp, int budget);
      int n = 0;
      while ((pend.size() > 0 || have_cur) && n < budget) begin
         tick(vp, hp, rp);
         n++;
      end
      chk("issue_timeout", 32'(pend.size() > 0 || have_cur), 32'd0);
   endtask

   task automatic drain(int budget);
      int n = 0;
      while (q.size() > 0 && n < budget) begin
         tick(0, 0, 100);
         n++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   function automatic req_t mk(bit w, int a, logic [W-1:0] d, logic [M-1:0] m);
      return '{is_write: w, mask: m, addr: AW'(a), data: d};
   endfunction

   initial begin
      int base, c0;
      for (int i = 0; i < H; i++) ref_mem[i] = init_val(i);
      bus.reqValid_i = 1'b0; bus.reqIsWrite_i = 1'b0; bus.reqMask_i = '0;
      bus.reqAddr_i = '0; bus.reqData_i = '0; bus.memHold_i = 1'b0; bus.rspReady_i = 1'b0;
      repeat (3) tick(0, 0, 0);
      chk("rst_rspValid", 32'(bus.rspValid_o), 32'd0);
      chk("rst_memEnable", 32'(bus.memEnable_o), 32'd0);
      chk("rst_reqReady", 32'(bus.reqReady_o), 32'd1);
      reset_n = 1'b1;
      repeat (2) tick(0, 0, 100);

      // masked write over a known word, then read it back
      pend.push_back(mk(1, 5, 16'h1234, 4'hF));
      pend.push_back(mk(1, 5, 16'hABCD, 4'b0011));
      issue_all(100, 0, 100, 20);
      drain(10);
      pend.push_back(mk(0, 5, '0, '0));
      issue_all(100, 0, 100, 20);
      drain(10);
      chk("masked_rd_data", 32'(last_rsp), 32'h12CD);
      chk("rd_latency", 32'(rv_rise - acc_cyc), 32'd2);

      // back-to-back reads with responses always taken
      base = n_pop; n_stall = 0; pop_cyc.delete();
      for (int a = 0; a < 8; a++) pend.push_back(mk(0, a, '0, '0));
      issue_all(100, 0, 100, 40);
      drain(10);
      chk("b2b_stall", 32'(n_stall), 32'd0);
      chk("b2b_pops", 32'(n_pop - base), 32'd8);
      chk("b2b_span", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[0]), 32'd7);

      // response backpressure: credit stops acceptance at RSP_DEPTH
      base = n_acc;
      for (int a = 10; a < 15; a++) pend.push_back(mk(0, a, '0, '0));
      repeat (10) tick(100, 0, 0);
      chk("bp_accepts", 32'(n_acc - base), 32'd3);
      chk("bp_ready_low", 32'(bus.reqReady_o), 32'd0);
      issue_all(100, 0, 100, 40);
      drain(10);

      // memory hold during a read
      base = n_acc;
      pend.push_back(mk(0, 9, '0, '0));
      repeat (4) tick(100, 100, 100);
      chk("hold_no_accept", 32'(n_acc - base), 32'd0);
      base = n_pop;
      c0 = cyc + 1;
      issue_all(100, 0, 100, 20);
      drain(10);
      chk("hold_accept_cyc", 32'(acc_cyc), 32'(c0));
      chk("hold_single_rsp", 32'(n_pop - base), 32'd1);

      // asynchronous reset with one read in flight and two buffered
      for (int a = 1; a < 4; a++) pend.push_back(mk(0, a, '0, '0));
      repeat (4) tick(100, 0, 0);
      chk("pre_rst_valid", 32'(bus.rspValid_o), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_rspValid", 32'(bus.rspValid_o), 32'd0);
      chk("async_rst_ready", 32'(bus.reqReady_o), 32'd1);
      have_cur = 1'b0;
      pend.delete();
      repeat (2) tick(0, 0, 0);
      reset_n = 1'b1;
      base = n_pop;
      pend.push_back(mk(0, 1, '0, '0));
      issue_all(100, 0, 100, 20);
      drain(10);
      chk("post_rst_pops", 32'(n_pop - base), 32'd1);
      chk("post_rst_data", 32'(last_rsp), 32'(init_val(1)));

`ifdef BI_MEM_WM_REQUESTER_WRACK_EN
      // write acknowledges stay in order with reads
      wr_seq = '0;
      pend.push_back(mk(1, 2, 16'h5555, 4'hF));
      pend.push_back(mk(0, 2, '0, '0));
      pend.push_back(mk(1, 3, 16'h0F0F, 4'h5));
      issue_all(100, 0, 100, 20);
      drain(10);
      chk("wrack_seq", 32'(wr_seq), 32'b101);
`endif

      // randomized traffic with hold and response backpressure
      for (int i = 0; i < 300; i++)
         pend.push_back(mk(1'($urandom), int'($urandom_range(H-1)), W'($urandom), M'($urandom)));
      issue_all(70, 25, 60, 5000);
      drain(100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
      $fatal(1);
   end
endmodule
